// File: rtl/neighbor_table_update.sv
// Merges a received beacon's node ID and cluster ID into the shared neighbour table in data memory.
// Define NEIGHBOR_CLUSTER_REFRESH_EN to rewrite a changed clusterID when the sender is already listed.
module neighbor_table_update #(
    parameter int unsigned MAX_NEIGHBORS = 64,
    parameter int unsigned WORD_WIDTH    = 16
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] rx_node_id,
    input  logic [WORD_WIDTH-1:0] rx_cluster_id,
    input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [10:0]           address,
    output logic                  wr_en,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  updated,
    output logic                  table_full,
    output logic                  done
);

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned IDX_W  = 7;

    localparam logic [ADDR_W-1:0] CNT_ADDR = 11'h68A;
    localparam logic [ADDR_W-1:0] ID_BASE  = 11'h048;
    localparam logic [ADDR_W-1:0] CL_BASE  = 11'h0C8;

    typedef enum logic [3:0] {
        IDLE,
        RDCNT,
        SCAN,
        RDCID,
        WRCID,
        WRID,
        WRCLU,
        WRCNT,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     address_q, address_d;
    logic                  wr_en_q, wr_en_d;
    logic [WORD_WIDTH-1:0] data_out_q, data_out_d;
    logic                  updated_q, updated_d;
    logic                  table_full_q, table_full_d;
    logic                  done_q, done_d;
    logic [WORD_WIDTH-1:0] node_id_q, node_id_d;
    logic [WORD_WIDTH-1:0] cluster_id_q, cluster_id_d;
    logic [IDX_W-1:0]      count_q, count_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    function automatic logic [ADDR_W-1:0] id_addr(input logic [IDX_W-1:0] idx);
        return ID_BASE + ADDR_W'({idx, 1'b0});
    endfunction

    function automatic logic [ADDR_W-1:0] cl_addr(input logic [IDX_W-1:0] idx);
        return CL_BASE + ADDR_W'({idx, 1'b0});
    endfunction

    // Write states present their {address, data_out} pair on entry; the completion
    // pulse is registered on the transition back to IDLE.
    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        wr_en_d      = 1'b0;
        data_out_d   = data_out_q;
        updated_d    = updated_q;
        table_full_d = table_full_q;
        done_d       = 1'b0;
        node_id_d    = node_id_q;
        cluster_id_d = cluster_id_q;
        count_d      = count_q;
        idx_d        = idx_q;

        case (state_q)
            IDLE: begin
                if (start && en) begin
                    node_id_d    = rx_node_id;
                    cluster_id_d = rx_cluster_id;
                    updated_d    = 1'b0;
                    table_full_d = 1'b0;
                    if (rx_node_id == MY_NODE_ID) begin
                        state_d = DONE;
                    end else begin
                        address_d = CNT_ADDR;
                        state_d   = RDCNT;
                    end
                end
            end

            RDCNT: begin
                // A corrupt count above capacity is clamped so the scan stays inside the table.
                if (data_in > WORD_WIDTH'(MAX_NEIGHBORS)) begin
                    count_d = IDX_W'(MAX_NEIGHBORS);
                end else begin
                    count_d = IDX_W'(data_in);
                end
                idx_d     = '0;
                address_d = ID_BASE;
                state_d   = SCAN;
            end

            SCAN: begin
                if (idx_q == count_q) begin
                    if (count_q >= IDX_W'(MAX_NEIGHBORS)) begin
                        table_full_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        address_d  = id_addr(count_q);
                        data_out_d = node_id_q;
                        wr_en_d    = 1'b1;
                        state_d    = WRID;
                    end
                end else if (data_in == node_id_q) begin
`ifdef NEIGHBOR_CLUSTER_REFRESH_EN
                    address_d = cl_addr(idx_q);
                    state_d   = RDCID;
`else
                    state_d   = DONE;
`endif
                end else begin
                    idx_d     = idx_q + IDX_W'(1);
                    address_d = id_addr(idx_q + IDX_W'(1));
                end
            end

            RDCID: begin
`ifdef NEIGHBOR_CLUSTER_REFRESH_EN
                if (data_in != cluster_id_q) begin
                    address_d  = cl_addr(idx_q);
                    data_out_d = cluster_id_q;
                    wr_en_d    = 1'b1;
                    updated_d  = 1'b1;
                    state_d    = WRCID;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`else
                done_d  = 1'b1;
                state_d = IDLE;
`endif
            end

            WRCID: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            WRID: begin
                address_d  = cl_addr(count_q);
                data_out_d = cluster_id_q;
                wr_en_d    = 1'b1;
                state_d    = WRCLU;
            end

            // Count goes out last so an interrupted append never exposes a half-written entry.
            WRCLU: begin
                address_d  = CNT_ADDR;
                data_out_d = WORD_WIDTH'(count_q) + WORD_WIDTH'(1);
                wr_en_d    = 1'b1;
                updated_d  = 1'b1;
                state_d    = WRCNT;
            end

            WRCNT: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= IDLE;
            address_q    <= CNT_ADDR;
            wr_en_q      <= 1'b0;
            data_out_q   <= '0;
            updated_q    <= 1'b0;
            table_full_q <= 1'b0;
            done_q       <= 1'b0;
            node_id_q    <= '0;
            cluster_id_q <= '0;
            count_q      <= '0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            wr_en_q      <= wr_en_d;
            data_out_q   <= data_out_d;
            updated_q    <= updated_d;
            table_full_q <= table_full_d;
            done_q       <= done_d;
            node_id_q    <= node_id_d;
            cluster_id_q <= cluster_id_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
        end
    end

    assign address    = address_q;
    assign wr_en      = wr_en_q;
    assign data_out   = data_out_q;
    assign updated    = updated_q;
    assign table_full = table_full_q;
    assign done       = done_q;

endmodule

// File: doc/neighbor_table_update.md
# neighbor_table_update

Upstream stage of the forAggregation check. On each received beacon it merges the sender's node ID and cluster ID into the shared neighbour table in data memory. The table consists of neighborCount at 0x68A, neighborID[i] at 0x48+2i and clusterID[i] at 0xC8+2i. The aggregation-check stage downstream scans exactly these locations, so this block must leave them consistent before that stage is started.

## Interface
Parameters:
- MAX_NEIGHBORS, 64 — table capacity; the ID region 0x48–0xC6 holds 64 words.
- WORD_WIDTH, 16 — memory and ID word width.

Ports:
- clock  in  1  — single clock, rising edge.
- rst  in  1  — synchronous, active-high reset.
- en  in  1  — block enable; start is honoured only while en=1.
- start  in  1  — one-cycle request; latches rx_node_id and rx_cluster_id.
- rx_node_id  in  16  — beacon sender ID.
- rx_cluster_id  in  16  — beacon sender cluster ID.
- MY_NODE_ID  in  16  — own ID; beacons from self are ignored.
- data_in  in  16  — memory read data, valid the cycle after address changes.
- address  out  11  — registered byte address.
- wr_en  out  1  — one-cycle write strobe for the {address, data_out} pair.
- data_out  out  16  — write data.
- updated  out  1  — table was modified by the last request; valid with done.
- table_full  out  1  — new neighbour dropped because count==MAX_NEIGHBORS.
- done  out  1  — one-cycle completion pulse.

## Operation
- States: IDLE, RDCNT, SCAN, RDCID, WRCID, WRID, WRCLU, WRCNT, DONE.
- IDLE:
  - On start&en, latch the rx fields and clear updated and table_full.
  - If rx_node_id==MY_NODE_ID, go to DONE.
  - Otherwise set address=0x68A and go to RDCNT.
- RDCNT: count=data_in, i=0, address=0x48, go to SCAN.
- SCAN, checked in this priority order:
  - i==count: this is a miss.
  - data_in==rx_node_id: this is a hit; set address=0xC8+2i and go to RDCID.
  - Otherwise i=i+1 and address=0x48+2i.
- RDCID:
  - If data_in!=rx_cluster_id (and the refresh feature is compiled in), go to WRCID.
  - Otherwise go to DONE.
- WRCID: address=0xC8+2i, data_out=rx_cluster_id, wr_en=1, updated=1, then DONE.
- Miss with count>=MAX_NEIGHBORS: table_full=1, no writes, go to DONE.
- Miss with room:
  - WRID writes rx_node_id to 0x48+2·count.
  - WRCLU writes rx_cluster_id to 0xC8+2·count.
  - WRCNT writes count+1 to 0x68A and sets updated=1.
  - Then DONE.
- The count is always written last. A reset in the middle of an append therefore leaves the stored table valid.
- DONE: wr_en=0, done=1 for one cycle, return to IDLE. updated and table_full are held until the next accepted start.
- Address arithmetic uses 11 bits; i is 7 bits wide. A count read above MAX_NEIGHBORS is treated as full, and no scan beyond MAX_NEIGHBORS is performed.

## Timing
- Reset values:
  - address=0x68A.
  - wr_en, data_out, updated, table_full and done = 0.
  - State = IDLE.
- A reset asserted in any state takes effect at the next edge; no further writes are issued.
- All outputs are registered. Edge 0 is the edge that samples start.
- Latency, with N = count and k = hit index:
  - Self beacon: done after edge 1.
  - Hit, cluster unchanged: done after edge k+3.
  - Hit, cluster changed: WRCID at edge k+3, done after edge k+4.
  - Miss with append: writes at edges N+2, N+3, N+4; done after edge N+5.
  - Miss with table full: done after edge N+3.
- start while not in IDLE is ignored. start with en=0 is ignored.
- wr_en is never high for two consecutive writes to the same address.

## Configuration
- NEIGHBOR_CLUSTER_REFRESH_EN defined: on a hit, the RDCID/WRCID path rewrites a changed clusterID and sets updated=1.
- NEIGHBOR_CLUSTER_REFRESH_EN undefined: on a hit, RDCID and WRCID are skipped. SCAN goes directly to DONE with updated=0, and done follows after edge k+3. Appends are unaffected.

## Test plan
- Empty table (0x68A=0), beacon id=0x0005 cluster=0x0002 -> writes mem[0x48]=5, mem[0xC8]=2, mem[0x68A]=1; updated=1; done after edge 5.
- Table {0x48:7, 0xC8:3, count=1}, beacon 7/3 -> no wr_en; updated=0; done after edge 3.
- Same table, beacon 7/9, with the macro -> single write mem[0xC8]=9, updated=1. Without the macro -> no write, updated=0.
- count=64, beacon with a new id -> no writes; table_full=1; done after edge 67.
- MY_NODE_ID=4, beacon id=4 -> no memory read and no write; done after edge 1.
- Assert rst in the cycle WRCLU is active during an append to count=2 -> mem[0x68A] stays 2; all outputs return to reset values; the next start is accepted normally.
